// File: rtl/hazard_scoreboard.sv
// Issue-side producer tracker: per-register result countdowns driving the ID stall for RAW, WAW and multiplier hazards.
// Latency: stall, mul_busy and pending_mask are combinational from the current state; state updates on each clk edge.
// Backpressure: stall holds PC and IF/ID and injects a bubble into ID/EX; ex_flush cancels the last issued entry.
// Optional: define HAZARD_SB_STATS_EN to add a saturating 16-bit stall_count output.
module hazard_scoreboard #(
    parameter int MUL_LAT  = 4,
    parameter int LOAD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [2:0] id_rs1,
    input  logic [2:0] id_rs2,
    input  logic       id_use_rs2,
    input  logic [2:0] id_rd,
    input  logic       id_regwrite,
    input  logic       id_is_load,
    input  logic       id_is_mul,
    input  logic       ex_flush,
    output logic       stall,
    output logic       mul_busy,
    output logic [7:0] pending_mask
`ifdef HAZARD_SB_STATS_EN
    ,
    output logic [15:0] stall_count
`endif
);

    // Remaining cycles until each register's result is forwardable; entry 0 is never written.
    logic [2:0] r_cnt [8];
    logic [2:0] r_mul_cnt;
    logic [2:0] r_last_rd;
    logic       r_last_is_mul;
    logic       r_last_valid;

    logic [2:0] w_lat_m1;
    logic       w_raw1;
    logic       w_raw2;
    logic       w_mul_struct;
    logic       w_waw;
    logic       w_issue;

    // Countdown value loaded for the instruction in ID (its latency minus one).
    always_comb begin
        w_lat_m1 = 3'd0;
        if (id_is_load)
            w_lat_m1 = 3'(LOAD_LAT - 1);
        else if (id_is_mul)
            w_lat_m1 = 3'(MUL_LAT - 1);
    end

    // Hazard terms; all use pre-issue state so rs == rd checks against the older producer.
    always_comb begin
        w_raw1       = (id_rs1 != 3'd0) && (r_cnt[id_rs1] != 3'd0);
        w_raw2       = id_use_rs2 && (id_rs2 != 3'd0) && (r_cnt[id_rs2] != 3'd0);
        w_mul_struct = id_is_mul && (r_mul_cnt != 3'd0);
        w_waw        = id_regwrite && (id_rd != 3'd0) && (r_cnt[id_rd] > w_lat_m1);
        stall        = id_valid && !ex_flush && (w_raw1 || w_raw2 || w_mul_struct || w_waw);
    end

    assign w_issue  = id_valid && !stall && !ex_flush;
    assign mul_busy = (r_mul_cnt != 3'd0);

    // Per-register pending flags; r0 always reads as ready.
    always_comb begin
        pending_mask = 8'h00;
        for (int i = 1; i < 8; i++)
            pending_mask[i] = (r_cnt[i] != 3'd0);
    end

    // Countdown update: decrement, then flush of the last issued entry, then new issue wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                r_cnt[i] <= 3'd0;
            r_mul_cnt     <= 3'd0;
            r_last_rd     <= 3'd0;
            r_last_is_mul <= 1'b0;
            r_last_valid  <= 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) begin
                if (w_issue && id_regwrite && (id_rd == 3'(i)))
                    r_cnt[i] <= w_lat_m1;
                else if (ex_flush && r_last_valid && (r_last_rd == 3'(i)))
                    r_cnt[i] <= 3'd0;
                else if (r_cnt[i] != 3'd0)
                    r_cnt[i] <= r_cnt[i] - 3'd1;
            end

            if (w_issue && id_is_mul)
                r_mul_cnt <= 3'(MUL_LAT - 1);
            else if (ex_flush && r_last_valid && r_last_is_mul)
                r_mul_cnt <= 3'd0;
            else if (r_mul_cnt != 3'd0)
                r_mul_cnt <= r_mul_cnt - 3'd1;

            r_last_valid  <= w_issue && id_regwrite && (id_rd != 3'd0);
            r_last_rd     <= id_rd;
            r_last_is_mul <= id_is_mul;
        end
    end

`ifdef HAZARD_SB_STATS_EN
    logic [15:0] r_stall_count;

    // Saturating count of clock edges on which ID was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_count <= 16'h0000;
        else if (stall && (r_stall_count != 16'hFFFF))
            r_stall_count <= r_stall_count + 16'h0001;
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default MUL_LAT=4, LOAD_LAT=2.
// Inputs driven on the falling edge; outputs compared 1 ns later, before the next rising edge.
// Each vector row is one clock: ID-stage inputs plus the expected pre-edge outputs.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rs1;
    logic [2:0] id_rs2;
    logic       id_use_rs2;
    logic [2:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic       id_is_mul;
    logic       ex_flush;
    logic       stall;
    logic       mul_busy;
    logic [7:0] pending_mask;
`ifdef HAZARD_SB_STATS_EN
    logic [15:0] stall_count;
`endif

    hazard_scoreboard #(.MUL_LAT(4), .LOAD_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_is_load   (id_is_load),
        .id_is_mul    (id_is_mul),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .mul_busy     (mul_busy),
        .pending_mask (pending_mask)
`ifdef HAZARD_SB_STATS_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       u2;
        logic [2:0] rd;
        logic       rw;
        logic       ld;
        logic       mul;
        logic       fl;
        logic       es;
        logic       eb;
        logic [7:0] em;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    task automatic add(input logic v, input logic [2:0] rs1, input logic [2:0] rs2, input logic u2,
                       input logic [2:0] rd, input logic rw, input logic ld, input logic mul,
                       input logic fl, input logic es, input logic eb, input logic [7:0] em);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.rw = rw;
        t.ld = ld; t.mul = mul; t.fl = fl; t.es = es; t.eb = eb; t.em = em;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid    = t.v;
        id_rs1      = t.rs1;
        id_rs2      = t.rs2;
        id_use_rs2  = t.u2;
        id_rd       = t.rd;
        id_regwrite = t.rw;
        id_is_load  = t.ld;
        id_is_mul   = t.mul;
        ex_flush    = t.fl;
    endtask

    task automatic step_check(input vec_t t, input string tag);
        @(negedge clk);
        drive(t);
        #1;
        check({tag, ".stall"}, {15'd0, stall}, {15'd0, t.es});
        check({tag, ".mul_busy"}, {15'd0, mul_busy}, {15'd0, t.eb});
        check({tag, ".pending_mask"}, {8'd0, pending_mask}, {8'd0, t.em});
`ifdef HAZARD_SB_STATS_EN
        check({tag, ".stall_count"}, stall_count, 16'(exp_cnt));
`endif
        if (t.es) exp_cnt++;
    endtask

    initial begin
        vec_t h;
        //   v rs1 rs2 u2 rd rw ld mul fl | stall busy mask
        // Load-use: one stall cycle
        add(1, 1, 0, 0, 3, 1, 1, 0, 0,   0, 0, 8'h00);  // LOAD r3
        add(1, 3, 1, 1, 4, 1, 0, 0, 0,   1, 0, 8'h08);  // ADD r4,r3,r1 stalls
        add(1, 3, 1, 1, 4, 1, 0, 0, 0,   0, 0, 8'h00);  // issues
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00);
        // MUL then dependent SUB: three stall cycles
        add(1, 1, 2, 1, 5, 1, 0, 1, 0,   0, 0, 8'h00);  // MUL r5
        add(1, 5, 2, 1, 6, 1, 0, 0, 0,   1, 1, 8'h20);
        add(1, 5, 2, 1, 6, 1, 0, 0, 0,   1, 1, 8'h20);
        add(1, 5, 2, 1, 6, 1, 0, 0, 0,   1, 1, 8'h20);
        add(1, 5, 2, 1, 6, 1, 0, 0, 0,   0, 0, 8'h00);  // SUB issues
        // Back-to-back MULs: structural stall until mul_busy drops
        add(1, 2, 3, 1, 1, 1, 0, 1, 0,   0, 0, 8'h00);  // MUL r1
        add(1, 3, 4, 1, 2, 1, 0, 1, 0,   1, 1, 8'h02);  // MUL r2 blocked
        add(1, 3, 4, 1, 2, 1, 0, 1, 0,   1, 1, 8'h02);
        add(1, 3, 4, 1, 2, 1, 0, 1, 0,   1, 1, 8'h02);
        add(1, 3, 4, 1, 2, 1, 0, 1, 0,   0, 0, 8'h00);  // issues
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 8'h04);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 8'h04);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 8'h04);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00);
        // r0 and ALU producers never stall
        add(1, 1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 8'h00);  // ADD r0
        add(1, 0, 0, 1, 3, 1, 0, 0, 0,   0, 0, 8'h00);  // reads r0
        add(1, 1, 0, 0, 2, 1, 0, 0, 0,   0, 0, 8'h00);  // ADD r2
        add(1, 2, 2, 1, 3, 1, 0, 0, 0,   0, 0, 8'h00);  // reads r2
        // WAW: MUL r1 then ALU write r1 held until cnt[r1]=0
        add(1, 2, 3, 1, 1, 1, 0, 1, 0,   0, 0, 8'h00);
        add(1, 2, 0, 0, 1, 1, 0, 0, 0,   1, 1, 8'h02);
        add(1, 2, 0, 0, 1, 1, 0, 0, 0,   1, 1, 8'h02);
        add(1, 2, 0, 0, 1, 1, 0, 0, 0,   1, 1, 8'h02);
        add(1, 2, 0, 0, 1, 1, 0, 0, 0,   0, 0, 8'h00);  // ALU r1 issues
        add(1, 1, 0, 0, 4, 1, 0, 0, 0,   0, 0, 8'h00);  // reader of r1
        // WAW boundary: LOAD r1 behind MUL r1 issues once cnt[r1] <= LOAD_LAT-1
        add(1, 2, 0, 0, 1, 1, 0, 1, 0,   0, 0, 8'h00);  // MUL r1
        add(1, 2, 0, 0, 1, 1, 1, 0, 0,   1, 1, 8'h02);  // LOAD r1, cnt=3
        add(1, 2, 0, 0, 1, 1, 1, 0, 0,   1, 1, 8'h02);  // cnt=2
        add(1, 2, 0, 0, 1, 1, 1, 0, 0,   0, 1, 8'h02);  // cnt=1, issues
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h02);  // load's own cnt=1
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00);
        // Flush of an issued MUL r7 cancels both its entry and the multiplier
        add(1, 1, 0, 0, 7, 1, 0, 1, 0,   0, 0, 8'h00);  // MUL r7
        add(1, 7, 0, 0, 4, 1, 0, 0, 1,   0, 1, 8'h80);  // flush, dependent in ID
        add(1, 7, 0, 0, 4, 1, 0, 0, 0,   0, 0, 8'h00);  // cleared
        // Flush of an issued LOAD r7
        add(1, 1, 0, 0, 7, 1, 1, 0, 0,   0, 0, 8'h00);  // LOAD r7
        add(1, 7, 0, 0, 4, 1, 0, 0, 1,   0, 0, 8'h80);  // flush suppresses stall
        add(1, 7, 0, 0, 4, 1, 0, 0, 0,   0, 0, 8'h00);

        h = '{v: 0, rs1: 0, rs2: 0, u2: 0, rd: 0, rw: 0, ld: 0, mul: 0, fl: 0, es: 0, eb: 0, em: 0};
        drive(h);
        rst_n = 1'b0;
        #2;
        check("reset.stall", {15'd0, stall}, 16'd0);
        check("reset.mul_busy", {15'd0, mul_busy}, 16'd0);
        check("reset.pending_mask", {8'd0, pending_mask}, 16'd0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step_check(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a MUL countdown
        h = '{v: 1, rs1: 1, rs2: 0, u2: 0, rd: 5, rw: 1, ld: 0, mul: 1, fl: 0, es: 0, eb: 0, em: 8'h00};
        step_check(h, "arst.mul");
        h = '{v: 1, rs1: 5, rs2: 0, u2: 0, rd: 6, rw: 1, ld: 0, mul: 0, fl: 0, es: 1, eb: 1, em: 8'h20};
        @(negedge clk);
        drive(h);
        #1;
        check("arst.pre_stall", {15'd0, stall}, 16'd1);
        check("arst.pre_mask", {8'd0, pending_mask}, 16'h0020);
        #2 rst_n = 1'b0;
        #1;
        check("arst.stall", {15'd0, stall}, 16'd0);
        check("arst.mul_busy", {15'd0, mul_busy}, 16'd0);
        check("arst.pending_mask", {8'd0, pending_mask}, 16'd0);
        exp_cnt = 0;
`ifdef HAZARD_SB_STATS_EN
        check("arst.stall_count", stall_count, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        // After reset the same dependent instruction proceeds freely
        h = '{v: 1, rs1: 5, rs2: 0, u2: 0, rd: 6, rw: 1, ld: 0, mul: 0, fl: 0, es: 0, eb: 0, em: 8'h00};
        step_check(h, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
